fmps_packet_tx: RTL
===================

Name: fmps_packet_tx

Overview:
Transmit-side counterpart of the FMPS link reader. On every auFAstrobe it snapshots the local FMPS status word and sends one FMPS packet onto an outgoing Aurora AXI-Stream link. Each packet is a header word followed by NUM_DATA_WORDS data words. The block sits between the local FMPS logic and the Aurora TX core; the CCW and CW link taps feed the reader.

Parameters:
INDEX_WIDTH, 5, width of the FMPS index field.
NUM_DATA_WORDS, 1, data words per packet (1..15).
HEADER_MAGIC, 16'hB6CF, header word bits [31:16].
COUNT_WIDTH, 16, width of the sent-packet and overrun counters.

Ports:
auClk  in  1  Aurora user clock; the only clock.
auReset  in  1  asynchronous, active-high reset.
auFAstrobe  in  1  single-cycle FA-rate strobe that starts a packet.
auChannelUp  in  1  Aurora channel status.
auInhibit  in  1  suppresses transmission; the cycle counter still advances.
auFMPSIndex  in  INDEX_WIDTH  this node's FMPS index.
auFMPSData  in  16  FMPS status payload.
auFMPSInvalid  in  2  {invalidFMPS2CC, invalidCC2CC} flags.
TX_tdata  out  32  AXI-Stream data.
TX_tvalid  out  1  AXI-Stream valid.
TX_tlast  out  1  AXI-Stream last.
TX_tready  in  1  AXI-Stream ready.
auCycleCounter  out  8  current FA cycle count.
auPacketCount  out  COUNT_WIDTH  completed packets (wraps).
auOverrunCount  out  COUNT_WIDTH  strobes dropped while busy (saturates).
auOverrunStrobe  out  1  one-cycle pulse on each dropped strobe.
auAbortStrobe  out  1  one-cycle pulse when a packet is abandoned.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, state ST_IDLE, counters 0.
- Cycle counter: on every auFAstrobe, whatever the state, the current value is captured for the packet and the counter then increments. It wraps 255->0.
- Snapshot at the strobe: auFMPSIndex, auFMPSData and auFMPSInvalid are registered. Later input changes do not affect the packet in flight.
- Header word: [31:16]=HEADER_MAGIC, [15]=0, [14:10]=index, [9:4]=0, [3:0]=NUM_DATA_WORDS.
- Data word: [31:30]=invalid flags, [29]=0, [28:24]=index, [23:8]=auFMPSData, [7:0]=captured cycle count. Every data word repeats the same content.
- FSM:
  - ST_IDLE: on auFAstrobe with auChannelUp=1 and auInhibit=0, go to ST_HEADER; tvalid rises the next cycle.
  - ST_HEADER: hold tvalid=1 and the header until tready=1, then go to ST_DATA with word index 0.
  - ST_DATA: on each accepted beat, advance the word index. tlast=1 only on word NUM_DATA_WORDS-1. On the last accept, increment auPacketCount and return to ST_IDLE.
- AXI rules:
  - tdata and tlast are stable while tvalid=1 and tready=0.
  - No tvalid bubbles inside a packet.
  - Minimum latency, strobe to first beat: 1 cycle.
  - With tready held high, a packet occupies exactly 1+NUM_DATA_WORDS cycles.
- Strobe while busy: the packet in flight continues unchanged. The strobe is dropped, auOverrunStrobe pulses, auOverrunCount increments (saturating), and the cycle counter still advances.
- Strobe in the same cycle as the final accept (tvalid&tready&tlast): this is an overrun. It is not queued, and the FSM goes to ST_IDLE.
- auChannelUp falls mid-packet: tvalid drops the next cycle, FSM goes to ST_IDLE, auAbortStrobe pulses, and auPacketCount is unchanged.
- auInhibit changing mid-packet: no effect on the packet in flight. Inhibit is sampled only at the strobe.
- Channel down or inhibit at the strobe: no packet and no overrun are recorded; only the cycle counter advances.
- Reset mid-packet: tvalid drops asynchronously and the partial packet is not completed.

Decomposition:
- Shared package fmps_pkg holds:
  - HEADER_MAGIC, DATA_MAGIC_WIDTH and INDEX_WIDTH defaults;
  - field bit positions (header magic [31:16], index [14:10]; data flags [31:30], index [28:24], payload [23:8], cycle [7:0]);
  - state encodings ST_IDLE, ST_HEADER, ST_DATA.
- The reader imports the same field constants.
- One natural sub-module: fmps_word_pack, combinational packing of the header and data words from the snapshot registers.

Test Plan:
- NUM_DATA_WORDS=1, tready=1, index=5, data=16'hCACA, strobe at cycle count 3 -> beats 32'hB6CF1401 then 32'h05CACA03 with tlast on the second beat; auPacketCount=1.
- tready randomized at p=0.5 over 100 strobes -> tdata and tlast stable under backpressure, no bubbles, 100 packets, auOverrunCount=0; feed the reader and it decodes with zero errors.
- Strobe every 2 cycles with tready=0 for 10 cycles -> header held; each extra strobe pulses auOverrunStrobe; auCycleCounter advances on every strobe.
- auChannelUp deasserted after the header is accepted -> tvalid=0 the next cycle, auAbortStrobe=1 for one cycle, auPacketCount unchanged; the next strobe with the channel up sends a full packet.
- 256 strobes with auInhibit=1 -> no tvalid; auCycleCounter wraps to 0; the first uninhibited packet carries cycle 0.
- auReset asserted mid-data beat -> tvalid=0 within the same cycle; all counters are 0 after release.

Source files
------------

// File: rtl/fmps_pkg.sv
// Shared FMPS link definitions: word field positions, defaults and FSM states.
// Imported by both the packet transmitter and the link reader.
package fmps_pkg;

  localparam logic [15:0] HEADER_MAGIC     = 16'hB6CF;
  localparam int          INDEX_WIDTH      = 5;
  // Reserved zero bits that separate the flags from the index in a data word.
  localparam int          DATA_MAGIC_WIDTH = 1;

  localparam int IDX_FIELD_W     = 5;
  localparam int HDR_MAGIC_LSB   = 16;
  localparam int HDR_INDEX_LSB   = 10;
  localparam int HDR_COUNT_LSB   = 0;
  localparam int DAT_FLAGS_LSB   = 30;
  localparam int DAT_INDEX_LSB   = 24;
  localparam int DAT_PAYLOAD_LSB = 8;
  localparam int DAT_CYCLE_LSB   = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } fmps_state_t;

endpackage

// File: rtl/fmps_word_pack.sv
// Combinational packing of the FMPS header and data words from the
// snapshot taken at the FA strobe.
module fmps_word_pack
  import fmps_pkg::*;
#(
  parameter int          NUM_DATA_WORDS = 1,
  parameter logic [15:0] MAGIC          = 16'hB6CF
) (
  input  logic [IDX_FIELD_W-1:0] i_index,
  input  logic [15:0]            i_payload,
  input  logic [1:0]             i_invalid,
  input  logic [7:0]             i_cycle,
  output logic [31:0]            o_header,
  output logic [31:0]            o_data
);

  always_comb begin
    o_header = '0;
    o_header[HDR_MAGIC_LSB +: 16]          = MAGIC;
    o_header[HDR_INDEX_LSB +: IDX_FIELD_W] = i_index;
    o_header[HDR_COUNT_LSB +: 4]           = 4'(NUM_DATA_WORDS);

    o_data = '0;
    o_data[DAT_FLAGS_LSB +: 2]                              = i_invalid;
    o_data[DAT_INDEX_LSB + IDX_FIELD_W +: DATA_MAGIC_WIDTH] = '0;
    o_data[DAT_INDEX_LSB +: IDX_FIELD_W]                    = i_index;
    o_data[DAT_PAYLOAD_LSB +: 16]                           = i_payload;
    o_data[DAT_CYCLE_LSB +: 8]                              = i_cycle;
  end

endmodule

// File: rtl/fmps_packet_tx.sv
// FMPS packet transmitter: on each FA strobe snapshots the local status and
// sends a header plus NUM_DATA_WORDS data words onto the Aurora TX stream.
module fmps_packet_tx
  import fmps_pkg::*;
#(
  parameter int          INDEX_WIDTH    = 5,
  parameter int          NUM_DATA_WORDS = 1,
  parameter logic [15:0] HEADER_MAGIC   = 16'hB6CF,
  parameter int          COUNT_WIDTH    = 16
) (
  input  logic                   auClk,
  input  logic                   auReset,
  input  logic                   auFAstrobe,
  input  logic                   auChannelUp,
  input  logic                   auInhibit,
  input  logic [INDEX_WIDTH-1:0] auFMPSIndex,
  input  logic [15:0]            auFMPSData,
  input  logic [1:0]             auFMPSInvalid,
  output logic [31:0]            TX_tdata,
  output logic                   TX_tvalid,
  output logic                   TX_tlast,
  input  logic                   TX_tready,
  output logic [7:0]             auCycleCounter,
  output logic [COUNT_WIDTH-1:0] auPacketCount,
  output logic [COUNT_WIDTH-1:0] auOverrunCount,
  output logic                   auOverrunStrobe,
  output logic                   auAbortStrobe
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_DATA_WORDS - 1);

  fmps_state_t            r_state;
  logic [3:0]             r_word_idx;
  logic                   r_tvalid;
  logic                   r_tlast;
  logic [7:0]             r_cycle;
  logic [7:0]             r_cycle_snap;
  logic [IDX_FIELD_W-1:0] r_index;
  logic [15:0]            r_payload;
  logic [1:0]             r_invalid;
  logic [COUNT_WIDTH-1:0] r_pkt_cnt;
  logic [COUNT_WIDTH-1:0] r_ovr_cnt;
  logic                   r_ovr_pulse;
  logic                   r_abort_pulse;

  logic                   w_start_ok;
  logic                   w_busy;
  logic                   w_accept;
  logic                   w_final;
  logic [IDX_FIELD_W-1:0] w_index_fit;
  logic [31:0]            w_header;
  logic [31:0]            w_data;

  assign w_start_ok  = auFAstrobe & auChannelUp & ~auInhibit;
  assign w_busy      = (r_state != ST_IDLE);
  assign w_accept    = r_tvalid & TX_tready;
  assign w_final     = w_accept & r_tlast;
  assign w_index_fit = IDX_FIELD_W'(auFMPSIndex);

  fmps_word_pack #(
    .NUM_DATA_WORDS(NUM_DATA_WORDS),
    .MAGIC         (HEADER_MAGIC)
  ) u_pack (
    .i_index  (r_index),
    .i_payload(r_payload),
    .i_invalid(r_invalid),
    .i_cycle  (r_cycle_snap),
    .o_header (w_header),
    .o_data   (w_data)
  );

  always_ff @(posedge auClk or posedge auReset) begin
    if (auReset) begin
      r_state       <= ST_IDLE;
      r_word_idx    <= '0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_cycle       <= '0;
      r_cycle_snap  <= '0;
      r_index       <= '0;
      r_payload     <= '0;
      r_invalid     <= '0;
      r_pkt_cnt     <= '0;
      r_ovr_cnt     <= '0;
      r_ovr_pulse   <= 1'b0;
      r_abort_pulse <= 1'b0;
    end else begin
      r_ovr_pulse   <= 1'b0;
      r_abort_pulse <= 1'b0;

      if (auFAstrobe) r_cycle <= r_cycle + 8'd1;

      // A valid strobe while busy (including the final-accept cycle) is dropped, never queued.
      if (w_start_ok && w_busy) begin
        r_ovr_pulse <= 1'b1;
        if (r_ovr_cnt != {COUNT_WIDTH{1'b1}}) r_ovr_cnt <= r_ovr_cnt + 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_index      <= w_index_fit;
            r_payload    <= auFMPSData;
            r_invalid    <= auFMPSInvalid;
            r_cycle_snap <= r_cycle;
            r_state      <= ST_HEADER;
            r_tvalid     <= 1'b1;
            r_tlast      <= 1'b0;
          end
        end
        ST_HEADER, ST_DATA: begin
          // A last beat already handed over completes the packet even if the link just dropped.
          if (!auChannelUp && !w_final) begin
            r_state       <= ST_IDLE;
            r_tvalid      <= 1'b0;
            r_tlast       <= 1'b0;
            r_word_idx    <= '0;
            r_abort_pulse <= 1'b1;
          end else if (w_accept) begin
            if (r_state == ST_HEADER) begin
              r_state    <= ST_DATA;
              r_word_idx <= '0;
              r_tlast    <= (LAST_IDX == 4'd0);
            end else if (r_tlast) begin
              r_state    <= ST_IDLE;
              r_tvalid   <= 1'b0;
              r_tlast    <= 1'b0;
              r_word_idx <= '0;
              r_pkt_cnt  <= r_pkt_cnt + 1'b1;
            end else begin
              r_word_idx <= r_word_idx + 4'd1;
              r_tlast    <= ((r_word_idx + 4'd1) == LAST_IDX);
            end
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_tvalid <= 1'b0;
          r_tlast  <= 1'b0;
        end
      endcase
    end
  end

  assign TX_tdata        = !r_tvalid ? 32'd0 : ((r_state == ST_DATA) ? w_data : w_header);
  assign TX_tvalid       = r_tvalid;
  assign TX_tlast        = r_tlast;
  assign auCycleCounter  = r_cycle;
  assign auPacketCount   = r_pkt_cnt;
  assign auOverrunCount  = r_ovr_cnt;
  assign auOverrunStrobe = r_ovr_pulse;
  assign auAbortStrobe   = r_abort_pulse;

endmodule
